// File: rtl/compare_pkg.sv
// Shared definitions for the bit-serial comparator: one-hot result codes
// and the controller state encoding.
package compare_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/compare_bit_cell.sv
// One step of an MSB-first magnitude compare: the first differing bit pair
// decides the result, later pairs cannot change it.
module compare_bit_cell (
  input  logic i_a_bit,
  input  logic i_b_bit,
  input  logic i_decided,
  input  logic i_gt,
  output logic o_decided,
  output logic o_gt
);

  always_comb begin
    o_decided = i_decided;
    o_gt      = i_gt;
    if (!i_decided && (i_a_bit != i_b_bit)) begin
      o_decided = 1'b1;
      o_gt      = i_a_bit;
    end
  end

endmodule

// File: rtl/serial_compare8.sv
// Bit-serial magnitude comparator: scans operand bit pairs MSB first, one
// pair per clock, and reports a one-hot GT/EQ/LT result with a done pulse.
module serial_compare8
  import compare_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oData,
  output state_t           oState
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: iStart is a request sampled only in IDLE or DONE; oBusy is high
  // throughout SHIFT; oDone is high for exactly the DONE cycle and oData is
  // valid from that cycle until the next DONE.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_decided;
  logic             r_gt;
  logic [2:0]       r_data;

  logic             w_load;
  logic             w_exit;
  logic             w_decided_nxt;
  logic             w_gt_nxt;

  compare_bit_cell u_cell (
    .i_a_bit   (r_sa[WIDTH-1]),
    .i_b_bit   (r_sb[WIDTH-1]),
    .i_decided (r_decided),
    .i_gt      (r_gt),
    .o_decided (w_decided_nxt),
    .o_gt      (w_gt_nxt)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_exit = (r_cnt == '0) || (EARLY_EXIT && w_decided_nxt && !r_decided);
        if (w_exit) w_state_nxt = DONE;
      end
      DONE: begin
        if (iStart) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sa      <= '0;
      r_sb      <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
      r_data    <= CMP_NONE;
    end else if (w_load) begin
      r_sa      <= iData_a;
      r_sb      <= iData_b;
      r_cnt     <= CNT_W'(WIDTH - 1);
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_sa      <= r_sa << 1;
      r_sb      <= r_sb << 1;
      // Hold at zero on the final step so the counter never wraps.
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      r_decided <= w_decided_nxt;
      r_gt      <= w_gt_nxt;
      if (w_exit) begin
        if (!w_decided_nxt) r_data <= CMP_EQ;
        else if (w_gt_nxt)  r_data <= CMP_GT;
        else                r_data <= CMP_LT;
      end
    end
  end

  assign oBusy  = (r_state == SHIFT);
  assign oDone  = (r_state == DONE);
  assign oData  = r_data;
  assign oState = r_state;

endmodule

// File: tb/tb_serial_compare8.sv
// Directed bench for serial_compare8: an early-exit and a full-scan instance
// share stimulus; results and latencies are checked against hand values.
module tb_serial_compare8;
  import compare_pkg::*;

  logic       iClk;
  logic       iRst_n;
  logic       iStart;
  logic [7:0] iData_a;
  logic [7:0] iData_b;
  logic       busy_e, done_e, busy_f, done_f;
  logic [2:0] data_e, data_f;
  state_t     st_e, st_f;

  int errors = 0;
  int checks = 0;

  serial_compare8 #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iData_a(iData_a),
    .iData_b(iData_b), .oBusy(busy_e), .oDone(done_e), .oData(data_e),
    .oState(st_e)
  );

  serial_compare8 #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iData_a(iData_a),
    .iData_b(iData_b), .oBusy(busy_f), .oDone(done_f), .oData(data_f),
    .oState(st_f)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Driver: issues one start and measures each instance's latency (edges after
  // the accepting edge until oDone is seen), result, early busy cycles, and
  // whether oDone is still high one cycle after the full-scan instance finishes.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat_e, output int lat_f,
                       output logic [2:0] res_e, output logic [2:0] res_f,
                       output int busy_cnt, output logic done_after);
    lat_e = -1; lat_f = -1; busy_cnt = 0;
    res_e = 'x; res_f = 'x;
    @(negedge iClk);
    iData_a = a; iData_b = b; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    if (busy_e) busy_cnt++;
    for (int i = 1; i <= 20 && (lat_e < 0 || lat_f < 0); i++) begin
      @(posedge iClk); #1;
      if (done_e && lat_e < 0) begin lat_e = i; res_e = data_e; end
      if (done_f && lat_f < 0) begin lat_f = i; res_f = data_f; end
      if (busy_e) busy_cnt++;
    end
    @(posedge iClk); #1;
    done_after = done_e | done_f;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; iStart = 1'b0; iData_a = '0; iData_b = '0;
    repeat (2) @(posedge iClk);
    #1;
    checks++;
    if ({busy_e, done_e, data_e, busy_f, done_f, data_f} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got e busy=%b done=%b data=%b f busy=%b done=%b data=%b, want all 0",
               busy_e, done_e, data_e, busy_f, done_f, data_f);
    end
    checks++;
    if (st_e !== IDLE || st_f !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d want IDLE", st_e, st_f);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0] va[8]  = '{8'h00, 8'h01, 8'h00, 8'hA5, 8'hFF, 8'hFF, 8'h56, 8'h3C};
    logic [7:0] vb[8]  = '{8'h00, 8'h00, 8'h02, 8'h5A, 8'h0F, 8'hF0, 8'hC9, 8'h3D};
    logic [2:0] vr[8]  = '{CMP_EQ, CMP_GT, CMP_LT, CMP_GT, CMP_GT, CMP_GT, CMP_LT, CMP_LT};
    int         vle[8] = '{8, 8, 7, 1, 1, 5, 1, 8};
    int le, lf, bc;
    logic [2:0] re, rf;
    logic da;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], le, lf, re, rf, bc, da);
      checks++;
      if (re !== vr[i]) begin
        errors++;
        $display("FAIL early_result[%0d]: got %b want %b", i, re, vr[i]);
      end
      checks++;
      if (rf !== vr[i]) begin
        errors++;
        $display("FAIL full_result[%0d]: got %b want %b", i, rf, vr[i]);
      end
      checks++;
      if (le != vle[i]) begin
        errors++;
        $display("FAIL early_latency[%0d]: got %0d want %0d", i, le, vle[i]);
      end
      checks++;
      if (lf != 8) begin
        errors++;
        $display("FAIL full_latency[%0d]: got %0d want 8", i, lf);
      end
      checks++;
      if (bc != vle[i]) begin
        errors++;
        $display("FAIL early_busy_cycles[%0d]: got %0d want %0d", i, bc, vle[i]);
      end
      checks++;
      if (da !== 1'b0) begin
        errors++;
        $display("FAIL done_single_pulse[%0d]: got %b want 0", i, da);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [2:0] res;
    lat = -1; res = 'x;
    @(negedge iClk);
    iData_a = 8'h00; iData_b = 8'h01; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iData_a = 8'hFF; iData_b = 8'h00; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int i = 5; i <= 20 && lat < 0; i++) begin
      @(posedge iClk); #1;
      if (done_e) begin lat = i; res = data_e; end
    end
    checks++;
    if (res !== CMP_LT || lat != 8) begin
      errors++;
      $display("FAIL start_in_shift_ignored: got res=%b lat=%0d want res=001 lat=8", res, lat);
    end
    repeat (2) @(posedge iClk);
  endtask

  task automatic test_back_to_back();
    int le, lf, k;
    logic [2:0] re, rf;
    le = -1; lf = -1; re = 'x; rf = 'x; k = 0;
    @(negedge iClk);
    iData_a = 8'h00; iData_b = 8'h00; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    while (!done_f && k < 20) begin
      @(posedge iClk); #1;
      k++;
    end
    checks++;
    if (!(done_e && done_f && data_e === CMP_EQ && data_f === CMP_EQ)) begin
      errors++;
      $display("FAIL b2b_first: got done=%b/%b data=%b/%b want done=1/1 data=010/010",
               done_e, done_f, data_e, data_f);
    end
    iData_a = 8'h56; iData_b = 8'hC9; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    checks++;
    if (!(busy_e && busy_f && !done_e && !done_f && data_e === CMP_EQ && data_f === CMP_EQ)) begin
      errors++;
      $display("FAIL b2b_no_gap: got busy=%b/%b done=%b/%b data=%b/%b want busy=1/1 done=0/0 data=010/010",
               busy_e, busy_f, done_e, done_f, data_e, data_f);
    end
    for (int i = 1; i <= 20 && (le < 0 || lf < 0); i++) begin
      @(posedge iClk); #1;
      if (done_e && le < 0) begin le = i; re = data_e; end
      if (done_f && lf < 0) begin lf = i; rf = data_f; end
    end
    checks++;
    if (re !== CMP_LT || rf !== CMP_LT || le != 1 || lf != 8) begin
      errors++;
      $display("FAIL b2b_second: got res=%b/%b lat=%0d/%0d want res=001/001 lat=1/8",
               re, rf, le, lf);
    end
    repeat (2) @(posedge iClk);
  endtask

  task automatic test_reset_mid_shift();
    int le, lf, bc, done_seen;
    logic [2:0] re, rf;
    logic da;
    do_op(8'hA5, 8'h5A, le, lf, re, rf, bc, da);
    @(negedge iClk);
    iData_a = 8'h00; iData_b = 8'h00; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (3) @(posedge iClk);
    #2;
    iRst_n = 1'b0;
    #1;
    checks++;
    if ({busy_e, done_e, data_e, busy_f, done_f, data_f} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got busy=%b/%b done=%b/%b data=%b/%b want all 0",
               busy_e, busy_f, done_e, done_f, data_e, data_f);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(posedge iClk); #1;
      if (done_e || done_f) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done cycles want 0", done_seen);
    end
    do_op(8'h12, 8'h34, le, lf, re, rf, bc, da);
    checks++;
    if (re !== CMP_LT || rf !== CMP_LT || le != 3 || lf != 8) begin
      errors++;
      $display("FAIL after_reset_op: got res=%b/%b lat=%0d/%0d want res=001/001 lat=3/8",
               re, rf, le, lf);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
